// File: rtl/adder_bist_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : adder_bist_pkg                                         |
// | Purpose : Shared types and helpers for the adder BIST driver:    |
// |           FSM state encoding, LFSR feedback mask and the golden  |
// |           reference sum.                                         |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package adder_bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } bist_state_t;

   // Galois feedback mask, applied when the bit shifted out is 1
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   // Operand width the golden model is sized for
   localparam int ADD_W = 8;

   // Full-width reference: carry lands in the top bit, nothing is truncated
   function automatic logic [ADD_W:0] golden_add(input logic [ADD_W-1:0] a,
                                                  input logic [ADD_W-1:0] b,
                                                  input logic             cin);
      return {1'b0, a} + {1'b0, b} + {{ADD_W{1'b0}}, cin};
   endfunction

endpackage
`default_nettype wire

// File: rtl/adder_8bit_bist_driver_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : adder_8bit_bist_driver_if                            |
// | Purpose   : Operand/result bus between the BIST driver and the   |
// |             adder under test.                                    |
// |   dut_a, dut_b, dut_cin : operands, driven by the BIST (master)  |
// |   dut_sum, dut_cout     : result, driven by the adder (slave)    |
// | Rev       : 1.0  initial release                                 |
// +------------------------------------------------------------------+
interface adder_8bit_bist_driver_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] dut_a;
   logic [WIDTH-1:0] dut_b;
   logic             dut_cin;
   logic [WIDTH-1:0] dut_sum;
   logic             dut_cout;

   modport master (
      output dut_a, dut_b, dut_cin,
      input  dut_sum, dut_cout
   );

   modport slave (
      input  dut_a, dut_b, dut_cin,
      output dut_sum, dut_cout
   );
endinterface
`default_nettype wire

// File: rtl/adder_8bit_bist_driver_lfsr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : bist_lfsr32                                            |
// | Purpose : 32-bit Galois LFSR vector source with seed reload.     |
// |   clk, rst_n : clock, async active-low reset (state <= SEED)     |
// |   i_load     : restart from SEED; o_vec shows SEED this cycle     |
// |   i_step     : advance one step                                   |
// |   o_vec      : low OUT_W bits of the vector being launched        |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module bist_lfsr32
   import adder_bist_pkg::*;
#(
   parameter logic [31:0] SEED  = 32'hACE1_0001,
   parameter int          OUT_W = 17
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_load,
   input  wire logic             i_step,
   output logic      [OUT_W-1:0] o_vec
);

   logic [31:0] r_lfsr;
   logic [31:0] w_cur;
   logic [31:0] w_nxt;

   // On load the seed itself is the vector launched this cycle, and the
   // register moves straight on to the state after it.
   assign w_cur = i_load ? SEED : r_lfsr;
   assign w_nxt = {1'b0, w_cur[31:1]} ^ (w_cur[0] ? LFSR_POLY : 32'h0);
   assign o_vec = w_cur[OUT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= SEED;
      end else if (i_load || i_step) begin
         r_lfsr <= w_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/adder_8bit_bist_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : adder_8bit_bist_driver                                 |
// | Purpose : On-chip stimulus/checker for the 8-bit adder. Launches |
// |           one pseudo-random a/b/cin vector per cycle, compares   |
// |           the adder result LATENCY+1 edges later against a       |
// |           golden a+b+cin and counts mismatches.                  |
// |   clk, rst_n : clock, async active-low reset                     |
// |   start      : run request, honoured in IDLE/DONE only           |
// |   bus        : operand/result bus to the adder (master side)     |
// |   busy       : high in RUN/DRAIN                                 |
// |   done, pass : run finished / finished with zero errors          |
// |   vec_count  : vectors compared so far                           |
// |   err_count  : mismatches so far, saturating                     |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module adder_8bit_bist_driver
   import adder_bist_pkg::*;
#(
   parameter int          WIDTH       = ADD_W,
   parameter int          NUM_VECTORS = 10000,
   parameter int          LATENCY     = 1,
   parameter int          CNT_W       = 16,
   parameter logic [31:0] SEED        = 32'hACE1_0001
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             start,
   adder_8bit_bist_driver_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic      [CNT_W-1:0] vec_count,
   output logic      [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0] c_ERR_MAX = '1;

   bist_state_t      r_state;
   bist_state_t      w_state_nxt;
   logic             w_load;
   logic             w_step;
   logic             w_launch;
   logic             w_finish;
   logic [2*WIDTH:0] w_vec;
   logic [WIDTH:0]   w_gold;

   logic [CNT_W-1:0] r_launch;
   logic [CNT_W-1:0] r_vec_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [CNT_W-1:0] w_err_nxt;
   logic             r_pass;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_cin;

   // Expected-result delay line; stage LATENCY lines up with the adder output
   logic [WIDTH:0]   r_exp [LATENCY+1];
   logic [LATENCY:0] r_vld;
   logic             w_pending;
   logic             w_compare;
   logic             w_mismatch;

   bist_lfsr32 #(
      .SEED  (SEED),
      .OUT_W (2*WIDTH+1)
   ) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_step (w_step),
      .o_vec  (w_vec)
   );

   assign w_gold = golden_add(w_vec[WIDTH-1:0], w_vec[2*WIDTH-1:WIDTH], w_vec[2*WIDTH]);

   // ---------------- FSM next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_load      = 1'b1;
               // A one-vector run has nothing left to launch after the start edge
               w_state_nxt = (NUM_VECTORS == 1) ? DRAIN : RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_launch == c_LAST) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!w_pending) begin
               w_state_nxt = DONE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_launch = w_load | w_step;

   // Entries still in flight ahead of the compare stage; once none remain,
   // the compare happening at this edge is the last one.
   always_comb begin
      w_pending = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         w_pending = w_pending | r_vld[i];
      end
   end

   assign w_finish   = (r_state == DRAIN) && !w_pending;
   assign w_compare  = r_vld[LATENCY];
   // Case inequality so that X/Z on the adder outputs counts as an error
   assign w_mismatch = w_compare && ({bus.dut_cout, bus.dut_sum} !== r_exp[LATENCY]);

   always_comb begin
      w_err_nxt = r_err_cnt;
      if (w_mismatch && (r_err_cnt != c_ERR_MAX)) begin
         w_err_nxt = r_err_cnt + CNT_W'(1);
      end
   end

   // ---------------- state, operands, counters ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_launch  <= '0;
         r_vec_cnt <= '0;
         r_err_cnt <= '0;
         r_pass    <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_cin     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_launch) begin
            r_a   <= w_vec[WIDTH-1:0];
            r_b   <= w_vec[2*WIDTH-1:WIDTH];
            r_cin <= w_vec[2*WIDTH];
         end
         if (w_load) begin
            r_launch  <= CNT_W'(1);
            r_vec_cnt <= '0;
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
         end else begin
            if (w_step) begin
               r_launch <= r_launch + CNT_W'(1);
            end
            if (w_compare) begin
               r_vec_cnt <= r_vec_cnt + CNT_W'(1);
            end
            r_err_cnt <= w_err_nxt;
            if (w_finish) begin
               r_pass <= (w_err_nxt == '0);
            end
         end
      end
   end

   // ---------------- expected-result delay line ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= LATENCY; i++) begin
            r_vld[i] <= 1'b0;
            r_exp[i] <= '0;
         end
      end else begin
         r_vld[0] <= w_launch;
         if (w_launch) begin
            r_exp[0] <= w_gold;
         end
         for (int i = 1; i <= LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_exp[i] <= r_exp[i-1];
         end
      end
   end

   assign bus.dut_a   = r_a;
   assign bus.dut_b   = r_b;
   assign bus.dut_cin = r_cin;
   assign busy        = (r_state == RUN) || (r_state == DRAIN);
   assign done        = (r_state == DONE);
   assign pass        = r_pass;
   assign vec_count   = r_vec_cnt;
   assign err_count   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adder_8bit_bist_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_adder_8bit_bist_driver                              |
// | Purpose : Self-checking bench. Four driver instances sit beside  |
// |           behavioural adders (latency 1 with fault hook, 0, 3,   |
// |           and a 4-bit-counter build with fault hook).            |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_adder_8bit_bist_driver;
   import adder_bist_pkg::*;

   localparam logic [31:0] c_SEED = 32'hACE1_0001;
   localparam logic [31:0] c_POLY = 32'h8020_0003;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] st = 4'b0;
   int         fault_a = 0;
   int         fault_d = 0;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   adder_8bit_bist_driver_if #(.WIDTH(8)) bus_a ();
   adder_8bit_bist_driver_if #(.WIDTH(8)) bus_b ();
   adder_8bit_bist_driver_if #(.WIDTH(8)) bus_c ();
   adder_8bit_bist_driver_if #(.WIDTH(8)) bus_d ();

   logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
   logic        busy_c, done_c, pass_c, busy_d, done_d, pass_d;
   logic [15:0] vc_a, ec_a, vc_b, ec_b, vc_c, ec_c;
   logic [3:0]  vc_d, ec_d;

   // ---------------- behavioural adders ----------------
   function automatic logic [8:0] faulty(input logic [8:0] s, input int mode);
      case (mode)
         1:       return s & 9'h1FE;   // sum[0] stuck at 0
         2:       return ~s;           // all outputs inverted
         default: return s;
      endcase
   endfunction

   logic [8:0] c_p1 = '0, c_p2 = '0;

   always @(posedge clk)
      {bus_a.dut_cout, bus_a.dut_sum} <= faulty(9'(bus_a.dut_a) + 9'(bus_a.dut_b) + 9'(bus_a.dut_cin), fault_a);
   always_comb
      {bus_b.dut_cout, bus_b.dut_sum} = 9'(bus_b.dut_a) + 9'(bus_b.dut_b) + 9'(bus_b.dut_cin);
   always @(posedge clk) begin
      c_p1 <= 9'(bus_c.dut_a) + 9'(bus_c.dut_b) + 9'(bus_c.dut_cin);
      c_p2 <= c_p1;
      {bus_c.dut_cout, bus_c.dut_sum} <= c_p2;
   end
   always @(posedge clk)
      {bus_d.dut_cout, bus_d.dut_sum} <= faulty(9'(bus_d.dut_a) + 9'(bus_d.dut_b) + 9'(bus_d.dut_cin), fault_d);

   // ---------------- DUTs ----------------
   adder_8bit_bist_driver #(.NUM_VECTORS(16), .LATENCY(1), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .bus(bus_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .vec_count(vc_a), .err_count(ec_a));
   adder_8bit_bist_driver #(.NUM_VECTORS(16), .LATENCY(0), .CNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .bus(bus_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .vec_count(vc_b), .err_count(ec_b));
   adder_8bit_bist_driver #(.NUM_VECTORS(16), .LATENCY(3), .CNT_W(16)) u_c (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .bus(bus_c), .busy(busy_c), .done(done_c),
      .pass(pass_c), .vec_count(vc_c), .err_count(ec_c));
   adder_8bit_bist_driver #(.NUM_VECTORS(15), .LATENCY(1), .CNT_W(4)) u_d (
      .clk(clk), .rst_n(rst_n), .start(st[3]), .bus(bus_d), .busy(busy_d), .done(done_d),
      .pass(pass_d), .vec_count(vc_d), .err_count(ec_d));

   // ---------------- per-unit accessors ----------------
   function automatic logic get_done(input int u);
      case (u) 0: return done_a; 1: return done_b; 2: return done_c; default: return done_d; endcase
   endfunction
   function automatic logic get_busy(input int u);
      case (u) 0: return busy_a; 1: return busy_b; 2: return busy_c; default: return busy_d; endcase
   endfunction
   function automatic logic get_pass(input int u);
      case (u) 0: return pass_a; 1: return pass_b; 2: return pass_c; default: return pass_d; endcase
   endfunction
   function automatic logic [15:0] get_vc(input int u);
      case (u) 0: return vc_a; 1: return vc_b; 2: return vc_c; default: return {12'b0, vc_d}; endcase
   endfunction
   function automatic logic [15:0] get_ec(input int u);
      case (u) 0: return ec_a; 1: return ec_b; 2: return ec_c; default: return {12'b0, ec_d}; endcase
   endfunction
   function automatic logic [16:0] get_vec(input int u);
      case (u)
         0:       return {bus_a.dut_cin, bus_a.dut_b, bus_a.dut_a};
         1:       return {bus_b.dut_cin, bus_b.dut_b, bus_b.dut_a};
         2:       return {bus_c.dut_cin, bus_c.dut_b, bus_c.dut_a};
         default: return {bus_d.dut_cin, bus_d.dut_b, bus_d.dut_a};
      endcase
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? c_POLY : 32'h0);
   endfunction

   // Vector k of a run = seed advanced k times; {cin, b, a}
   function automatic logic [16:0] ref_vec(input int k);
      logic [31:0] s = c_SEED;
      for (int i = 0; i < k; i++) s = lfsr_next(s);
      return s[16:0];
   endfunction

   function automatic int ref_errs(input int n, input int mode, input int cnt_w);
      int e = 0;
      for (int k = 0; k < n; k++) begin
         logic [16:0] v = ref_vec(k);
         int expv = int'(v[7:0]) + int'(v[15:8]) + int'(v[16]);
         int obs  = expv;
         if (mode == 1) obs = expv & 'h1FE;
         if (mode == 2) obs = (~expv) & 'h1FF;
         if (obs != expv) e++;
      end
      if (e > (1 << cnt_w) - 1) e = (1 << cnt_w) - 1;
      return e;
   endfunction

   // Start a run on unit u and wait for done. cycles = edges after the start
   // edge until done is seen; vec_bad/busy_bad count off-model samples.
   task automatic run_unit(input int u, input int n, output int cycles, output int vec_bad,
                           output int busy_bad, output logic done_s, output logic pass_s);
      @(negedge clk);
      st[u] = 1'b1;
      @(posedge clk); #1;
      st[u]    = 1'b0;
      cycles   = 0;
      vec_bad  = 0;
      busy_bad = 0;
      done_s   = get_done(u);
      pass_s   = get_pass(u);
      if (get_vec(u) !== ref_vec(0)) vec_bad++;
      if (get_busy(u) !== 1'b1) busy_bad++;
      while (get_done(u) !== 1'b1 && cycles < 300) begin
         @(posedge clk); #1;
         cycles++;
         if (get_vec(u) !== ref_vec(cycles < n ? cycles : n - 1)) vec_bad++;
         if (get_busy(u) !== !get_done(u)) busy_bad++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         st      = 4'($urandom);
         fault_a = int'($urandom_range(0, 2));
      end
      @(posedge clk); #1;
      for (int u = 0; u < 4; u++) begin
         checks++;
         if ({get_busy(u), get_done(u), get_pass(u)} !== 3'b000 || get_vc(u) !== 16'd0 ||
             get_ec(u) !== 16'd0 || get_vec(u) !== 17'd0) begin
            errors++;
            $display("FAIL reset_u%0d: busy/done/pass=%b%b%b vc=%0d ec=%0d vec=%h, required all 0",
                     u, get_busy(u), get_done(u), get_pass(u), get_vc(u), get_ec(u), get_vec(u));
         end
      end
      @(negedge clk);
      st      = 4'b0;
      fault_a = 0;
      rst_n   = 1'b1;
      repeat ($urandom_range(3, 8)) @(posedge clk);
      #1;
      for (int u = 0; u < 4; u++) begin
         checks++;
         if (get_busy(u) !== 1'b0 || get_done(u) !== 1'b0) begin
            errors++;
            $display("FAIL idle_u%0d: busy=%b done=%b, required 0 0", u, get_busy(u), get_done(u));
         end
      end
   endtask

   task automatic test_golden();
      logic [8:0] g = golden_add(8'h00, 8'hFF, 1'b1);
      checks++;
      if (g !== 9'h100) begin
         errors++;
         $display("FAIL golden_00_FF_1: got %h, required 100", g);
      end
      for (int i = 0; i < 4; i++) begin
         logic [7:0] a = 8'($urandom);
         logic [7:0] b = 8'($urandom);
         logic       c = 1'($urandom);
         int         want = int'(a) + int'(b) + int'(c);
         g = golden_add(a, b, c);
         checks++;
         if (int'(g) != want) begin
            errors++;
            $display("FAIL golden_rand: %h+%h+%b got %0d, required %0d", a, b, c, g, want);
         end
      end
   endtask

   task automatic check_run(input string name, input int u, input int n, input int lat,
                            input int mode, input int cnt_w);
      int   cyc, vb, bb, want_e;
      logic ds, ps;
      run_unit(u, n, cyc, vb, bb, ds, ps);
      want_e = ref_errs(n, mode, cnt_w);
      checks++;
      if (cyc != n + lat) begin
         errors++;
         $display("FAIL %s_cycles: done after %0d edges, required %0d", name, cyc, n + lat);
      end
      checks++;
      if (get_vc(u) !== 16'(n)) begin
         errors++;
         $display("FAIL %s_vec_count: got %0d, required %0d", name, get_vc(u), n);
      end
      checks++;
      if (get_ec(u) !== 16'(want_e)) begin
         errors++;
         $display("FAIL %s_err_count: got %0d, required %0d", name, get_ec(u), want_e);
      end
      checks++;
      if (get_pass(u) !== (want_e == 0)) begin
         errors++;
         $display("FAIL %s_pass: got %b, required %b", name, get_pass(u), want_e == 0);
      end
      checks++;
      if (vb != 0 || bb != 0) begin
         errors++;
         $display("FAIL %s_vectors_busy: %0d bad vectors, %0d bad busy samples, required 0 0", name, vb, bb);
      end
      checks++;
      if (ds !== 1'b0 || ps !== 1'b0) begin
         errors++;
         $display("FAIL %s_clear_on_start: done=%b pass=%b after start edge, required 0 0", name, ds, ps);
      end
   endtask

   task automatic test_clean_run();
      check_run("clean", 0, 16, 1, 0, 16);
   endtask

   task automatic test_stuck_sum0();
      fault_a = 1;
      check_run("stuck_sum0", 0, 16, 1, 1, 16);
      fault_a = 0;
   endtask

   task automatic test_latency();
      check_run("lat0", 1, 16, 0, 0, 16);
      check_run("lat3", 2, 16, 3, 0, 16);
   endtask

   task automatic test_start_ignored();
      int cyc = 0;
      int gap = int'($urandom_range(3, 10));
      @(negedge clk); st[0] = 1'b1;
      @(posedge clk); #1; st[0] = 1'b0;
      repeat (gap - 1) begin @(posedge clk); #1; cyc++; end
      @(negedge clk); st[0] = 1'b1;
      @(posedge clk); #1; st[0] = 1'b0; cyc++;
      // compares happen from edge S+2 on, so c edges after S give c-1 compares
      checks++;
      if (vc_a !== 16'(cyc - 1) || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL start_ignored_mid: vc=%0d busy=%b, required %0d 1", vc_a, busy_a, cyc - 1);
      end
      while (done_a !== 1'b1 && cyc < 300) begin @(posedge clk); #1; cyc++; end
      checks++;
      if (cyc != 17 || vc_a !== 16'd16 || ec_a !== 16'd0 || pass_a !== 1'b1) begin
         errors++;
         $display("FAIL start_ignored_end: cycles=%0d vc=%0d ec=%0d pass=%b, required 17 16 0 1",
                  cyc, vc_a, ec_a, pass_a);
      end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk); st[0] = 1'b1;
      @(posedge clk); #1; st[0] = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || vc_a !== 16'd0 ||
          ec_a !== 16'd0 || get_vec(0) !== 17'd0) begin
         errors++;
         $display("FAIL reset_mid_run: busy=%b done=%b pass=%b vc=%0d ec=%0d vec=%h, required all 0",
                  busy_a, done_a, pass_a, vc_a, ec_a, get_vec(0));
      end
      @(negedge clk); rst_n = 1'b1;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      check_run("after_reset", 0, 16, 1, 0, 16);
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 2; r++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         check_run("restart", 0, 16, 1, 0, 16);
      end
   endtask

   task automatic test_saturation();
      fault_d = 2;
      check_run("sat_invert", 3, 15, 1, 2, 4);
      fault_d = 0;
      check_run("sat_clean", 3, 15, 1, 0, 4);
   endtask

   initial begin
      test_reset();
      test_golden();
      test_clean_run();
      test_stuck_sum0();
      test_latency();
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
